// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: resolves data-memory waits, EX redirects and
// load-use hazards, with a wait timeout that traps into a sticky error state.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_valid,
  input  logic        ex_load,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  input  logic        ex_redirect,
  input  logic [31:0] redirect_target,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic [1:0]  state,
  output logic        err,
  output logic [15:0] stall_cycles,
  output logic [15:0] redirect_count
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_pending;
  logic [ADDR_W-1:0]   r_target;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_err;
  logic [CNT_W-1:0]    r_stall_cycles;
  logic [CNT_W-1:0]    r_redirect_count;

  logic                w_rs1_hit;
  logic                w_rs2_hit;
  logic                w_load_use;
  logic                w_mem_busy;
  logic                w_stall_all;
  logic                w_bubble;
  logic                w_redir;
  logic [ADDR_W-1:0]   w_redir_tgt;

  assign w_rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign w_load_use = id_valid && ex_load && ex_reg_write && (ex_rd != 5'd0)
                      && (w_rs1_hit || w_rs2_hit);
  assign w_mem_busy = dmem_req && !dmem_ack;

  // Hazard decision for the current cycle; reset masks every action.
  always_comb begin
    w_stall_all = 1'b0;
    w_bubble    = 1'b0;
    w_redir     = 1'b0;
    w_redir_tgt = '0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (w_mem_busy) begin
            w_stall_all = 1'b1;
          end else if (ex_redirect) begin
            w_redir     = 1'b1;
            w_redir_tgt = redirect_target;
          end else if (w_load_use) begin
            w_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!dmem_ack) begin
            w_stall_all = 1'b1;
          end else if (r_pending) begin
            w_redir     = 1'b1;
            w_redir_tgt = r_target;
          end else if (w_load_use) begin
            w_bubble = 1'b1;
          end
        end
        ERROR:   w_stall_all = 1'b1;
        default: w_stall_all = 1'b0;
      endcase
    end
  end

  assign pc_stall     = w_stall_all || w_bubble;
  assign if_id_stall  = w_stall_all || w_bubble;
  assign id_ex_stall  = w_stall_all;
  assign ex_mem_stall = w_stall_all;
  assign if_id_flush  = w_redir;
  assign id_ex_flush  = w_redir || w_bubble;
  assign pc_redirect  = w_redir;
  assign pc_target    = w_redir ? w_redir_tgt : '0;

  // State, deferred redirect, wait timer and saturating perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= RUN;
      r_pending        <= 1'b0;
      r_target         <= '0;
      r_wait           <= '0;
      r_err            <= 1'b0;
      r_stall_cycles   <= '0;
      r_redirect_count <= '0;
    end else begin
      if (pc_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (pc_redirect && (r_redirect_count != '1)) begin
        r_redirect_count <= r_redirect_count + CNT_W'(1);
      end
      case (r_state)
        RUN: begin
          if (w_mem_busy) begin
            r_state <= MEM_WAIT;
            r_wait  <= '0;
            if (ex_redirect) begin
              r_pending <= 1'b1;
              r_target  <= redirect_target;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            r_state   <= RUN;
            r_wait    <= '0;
            r_pending <= 1'b0;
          end else if (r_wait == '1) begin
            r_state <= ERROR;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ERROR:   r_state <= ERROR;
        default: r_state <= RUN;
      endcase
    end
  end

  assign state          = r_state;
  assign err            = r_err;
  assign stall_cycles   = r_stall_cycles;
  assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expected outputs are queued
// as stimulus is driven and popped at the following falling edge.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, id_valid, ex_load, ex_reg_write;
  logic        ex_redirect, dmem_req, dmem_ack;
  logic [31:0] redirect_target;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, pc_redirect;
  logic [31:0] pc_target;
  logic [1:0]  state;
  logic        err;
  logic [15:0] stall_cycles, redirect_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_valid(id_valid),
    .ex_load(ex_load), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .redirect_target(redirect_target),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .state(state), .err(err),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs1, rs2;
    logic        u1, u2, v, ld, wr;
    logic [4:0]  rd;
    logic        redir;
    logic [31:0] tgt;
    logic        req, ack;
  } in_t;

  // stl = {pc, if_id, id_ex, ex_mem} stalls; fl = {if_id, id_ex} flushes
  typedef struct packed {
    logic [3:0]  stl;
    logic [1:0]  fl;
    logic        rd;
    logic [31:0] tgt;
    logic [1:0]  st;
    logic        er;
  } out_t;

  out_t exp_q[$];

  function automatic in_t mkin(input logic lu, input logic [4:0] rd, input logic redir,
                               input logic [31:0] tgt, input logic req, input logic ack);
    in_t s = '0;
    s.ld = lu; s.wr = lu; s.u1 = lu; s.v = lu;
    s.rs1 = rd; s.rd = rd;
    s.redir = redir; s.tgt = tgt; s.req = req; s.ack = ack;
    return s;
  endfunction

  function automatic out_t mk(input logic [3:0] stl, input logic [1:0] fl, input logic rd,
                              input logic [31:0] tgt, input logic [1:0] st, input logic er);
    out_t o;
    o.stl = stl; o.fl = fl; o.rd = rd; o.tgt = tgt; o.st = st; o.er = er;
    return o;
  endfunction

  function automatic out_t cur();
    out_t o;
    o.stl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall};
    o.fl  = {if_id_flush, id_ex_flush};
    o.rd  = pc_redirect;
    o.tgt = pc_target;
    o.st  = state;
    o.er  = err;
    return o;
  endfunction

  task automatic drive(input in_t s);
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; id_valid = s.v;
    ex_load = s.ld; ex_reg_write = s.wr; ex_rd = s.rd;
    ex_redirect = s.redir; redirect_target = s.tgt;
    dmem_req = s.req; dmem_ack = s.ack;
  endtask

  localparam out_t ZERO = '0;

  task automatic test_reset();
    in_t si[$]; out_t xo[$]; out_t e, g; in_t s;
    s = mkin(1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0); s.rst = 1'b1;
    drive(s); @(posedge clk); #1;
    si.push_back(s); xo.push_back(ZERO);
    si.push_back(s); xo.push_back(ZERO);
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0)); xo.push_back(ZERO);
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]); exp_q.push_back(xo[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL reset[%0d] got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
    n_tests++;
    if (stall_cycles !== 16'd0 || redirect_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters got=%h/%h exp=0/0", stall_cycles, redirect_count);
    end
  endtask

  task automatic test_load_use();
    in_t si[$]; out_t xo[$]; out_t e, g; in_t s;
    si.push_back(mkin(1'b1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0));
    xo.push_back(mk(4'b1100, 2'b01, 1'b0, 32'h0, 2'd0, 1'b0));
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0)); xo.push_back(ZERO);
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]); exp_q.push_back(xo[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL load_use[%0d] got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
    n_tests++;
    if (stall_cycles !== 16'd1) begin
      n_fail++; $display("FAIL load_use_count got=%0d exp=1", stall_cycles);
    end
    si.delete(); xo.delete();
    s = mkin(1'b1, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0);
    s.u1 = 1'b0; s.u2 = 1'b1; s.rs2 = 5'd7; s.rs1 = 5'd3;
    si.push_back(s); xo.push_back(mk(4'b1100, 2'b01, 1'b0, 32'h0, 2'd0, 1'b0));
    s = mkin(1'b1, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0); s.v = 1'b0;
    si.push_back(s); xo.push_back(ZERO);
    s = mkin(1'b1, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0); s.u1 = 1'b0;
    si.push_back(s); xo.push_back(ZERO);
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]); exp_q.push_back(xo[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL load_use_var[%0d] got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_no_hazard();
    in_t si[$]; out_t xo[$]; out_t e, g; in_t s;
    si.push_back(mkin(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0)); xo.push_back(ZERO);
    s = mkin(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0); s.rs1 = 5'd5;
    si.push_back(s); xo.push_back(ZERO);
    s = mkin(1'b1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0); s.wr = 1'b0;
    si.push_back(s); xo.push_back(ZERO);
    s = mkin(1'b1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0); s.ld = 1'b0;
    si.push_back(s); xo.push_back(ZERO);
    s = mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    si.push_back(s); xo.push_back(ZERO);
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]); exp_q.push_back(xo[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL no_hazard[%0d] got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
    n_tests++;
    if (stall_cycles !== 16'd2) begin
      n_fail++; $display("FAIL no_hazard_count got=%0d exp=2", stall_cycles);
    end
  endtask

  task automatic test_redirect();
    in_t si[$]; out_t xo[$]; out_t e, g;
    si.push_back(mkin(1'b1, 5'd5, 1'b1, 32'h0000_0080, 1'b0, 1'b0));
    xo.push_back(mk(4'b0000, 2'b11, 1'b1, 32'h0000_0080, 2'd0, 1'b0));
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0000_0080, 1'b0, 1'b0)); xo.push_back(ZERO);
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]); exp_q.push_back(xo[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL redirect[%0d] got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
    n_tests++;
    if (redirect_count !== 16'd1 || stall_cycles !== 16'd2) begin
      n_fail++; $display("FAIL redirect_count got=%0d/%0d exp=1/2", redirect_count, stall_cycles);
    end
  endtask

  task automatic test_mem_redirect();
    in_t si[$]; out_t xo[$]; out_t e, g;
    si.push_back(mkin(1'b1, 5'd5, 1'b1, 32'h0000_0100, 1'b1, 1'b0));
    xo.push_back(mk(4'b1111, 2'b00, 1'b0, 32'h0, 2'd0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      si.push_back(mkin(1'b1, 5'd5, 1'b1, 32'h0000_0200, 1'b1, 1'b0));
      xo.push_back(mk(4'b1111, 2'b00, 1'b0, 32'h0, 2'd1, 1'b0));
    end
    si.push_back(mkin(1'b1, 5'd5, 1'b1, 32'h0000_0200, 1'b1, 1'b1));
    xo.push_back(mk(4'b0000, 2'b11, 1'b1, 32'h0000_0100, 2'd1, 1'b0));
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0)); xo.push_back(ZERO);
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]); exp_q.push_back(xo[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL mem_redirect[%0d] got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
    n_tests++;
    if (redirect_count !== 16'd2 || stall_cycles !== 16'd6) begin
      n_fail++; $display("FAIL mem_redirect_count got=%0d/%0d exp=2/6", redirect_count, stall_cycles);
    end
  endtask

  task automatic test_mem_load_use();
    in_t si[$]; out_t xo[$]; out_t e, g;
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0));
    xo.push_back(mk(4'b1111, 2'b00, 1'b0, 32'h0, 2'd0, 1'b0));
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0));
    xo.push_back(mk(4'b1111, 2'b00, 1'b0, 32'h0, 2'd1, 1'b0));
    si.push_back(mkin(1'b1, 5'd9, 1'b0, 32'h0, 1'b1, 1'b1));
    xo.push_back(mk(4'b1100, 2'b01, 1'b0, 32'h0, 2'd1, 1'b0));
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0)); xo.push_back(ZERO);
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]); exp_q.push_back(xo[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL mem_load_use[%0d] got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    in_t si[$]; out_t xo[$]; out_t e, g;
    si.push_back(mkin(1'b0, 5'd0, 1'b1, 32'h0000_0010, 1'b0, 1'b0));
    xo.push_back(mk(4'b0000, 2'b11, 1'b1, 32'h0000_0010, 2'd0, 1'b0));
    si.push_back(mkin(1'b0, 5'd0, 1'b1, 32'h0000_0020, 1'b0, 1'b0));
    xo.push_back(mk(4'b0000, 2'b11, 1'b1, 32'h0000_0020, 2'd0, 1'b0));
    si.push_back(mkin(1'b1, 5'd3, 1'b0, 32'h0, 1'b0, 1'b0));
    xo.push_back(mk(4'b1100, 2'b01, 1'b0, 32'h0, 2'd0, 1'b0));
    si.push_back(mkin(1'b1, 5'd31, 1'b0, 32'h0, 1'b0, 1'b0));
    xo.push_back(mk(4'b1100, 2'b01, 1'b0, 32'h0, 2'd0, 1'b0));
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0)); xo.push_back(ZERO);
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]); exp_q.push_back(xo[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
    n_tests++;
    if (redirect_count !== 16'd4 || stall_cycles !== 16'd11) begin
      n_fail++; $display("FAIL b2b_count got=%0d/%0d exp=4/11", redirect_count, stall_cycles);
    end
  endtask

  task automatic test_timeout();
    in_t si[$]; out_t xo[$]; out_t e, g; in_t s;
    si.push_back(mkin(1'b0, 5'd0, 1'b1, 32'h0000_0300, 1'b1, 1'b0));
    xo.push_back(mk(4'b1111, 2'b00, 1'b0, 32'h0, 2'd0, 1'b0));
    for (int k = 0; k < 256; k++) begin
      si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0));
      xo.push_back(mk(4'b1111, 2'b00, 1'b0, 32'h0, 2'd1, 1'b0));
    end
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0));
    xo.push_back(mk(4'b1111, 2'b00, 1'b0, 32'h0, 2'd2, 1'b1));
    for (int k = 0; k < 2; k++) begin
      si.push_back(mkin(1'b1, 5'd5, 1'b1, 32'h0000_0500, 1'b1, 1'b1));
      xo.push_back(mk(4'b1111, 2'b00, 1'b0, 32'h0, 2'd2, 1'b1));
    end
    s = mkin(1'b1, 5'd5, 1'b1, 32'h0000_0400, 1'b1, 1'b0); s.rst = 1'b1;
    si.push_back(s); xo.push_back(mk(4'b0000, 2'b00, 1'b0, 32'h0, 2'd2, 1'b1));
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0)); xo.push_back(ZERO);
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]); exp_q.push_back(xo[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL timeout[%0d] got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
    n_tests++;
    if (stall_cycles !== 16'd0 || redirect_count !== 16'd0) begin
      n_fail++; $display("FAIL timeout_rst_counters got=%h/%h exp=0/0", stall_cycles, redirect_count);
    end
    si.delete(); xo.delete();
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0));
    xo.push_back(mk(4'b1111, 2'b00, 1'b0, 32'h0, 2'd0, 1'b0));
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1));
    xo.push_back(mk(4'b0000, 2'b00, 1'b0, 32'h0, 2'd1, 1'b0));
    si.push_back(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0)); xo.push_back(ZERO);
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]); exp_q.push_back(xo[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL pending_discard[%0d] got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
    n_tests++;
    if (redirect_count !== 16'd0 || stall_cycles !== 16'd1) begin
      n_fail++; $display("FAIL discard_count got=%0d/%0d exp=0/1", redirect_count, stall_cycles);
    end
  endtask

  task automatic test_saturation();
    in_t s; out_t e, g;
    s = mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0); s.rst = 1'b1;
    drive(s); @(posedge clk); #1;
    drive(mkin(1'b1, 5'd12, 1'b0, 32'h0, 1'b0, 1'b0));
    repeat (65535) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cycles !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_reach got=%h exp=ffff", stall_cycles);
    end
    drive(mkin(1'b1, 5'd12, 1'b0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b1100, 2'b01, 1'b0, 32'h0, 2'd0, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); g = cur(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL sat_out got=%h exp=%h", g, e); end
    @(posedge clk); #1;
    n_tests++;
    if (stall_cycles !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold got=%h exp=ffff", stall_cycles);
    end
    drive(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0));
  endtask

  initial begin
    drive(mkin(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0));
    rst = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect();
    test_mem_redirect();
    test_mem_load_use();
    test_back_to_back();
    test_timeout();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have ports id_rs1 and id_rs2, input, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have ports id_uses_rs1, id_uses_rs2 and id_valid, input, 1 bit each: ID operand-use flags and ID-valid flag.
REQ-005 SHALL have ports ex_load, ex_reg_write (input, 1 bit each) and ex_rd (input, 5 bits): EX-stage load flag, write-enable and destination register.
REQ-006 SHALL have ports ex_redirect (input, 1 bit: taken branch or jalr in EX) and redirect_target (input, 32 bits).
REQ-007 SHALL have ports dmem_req and dmem_ack, input, 1 bit each: data-memory access request and completion.
REQ-008 SHALL have ports pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush and pc_redirect, output, 1 bit each.
REQ-009 SHALL have port pc_target, output, 32 bits: redirect address, valid when pc_redirect=1.
REQ-010 SHALL have ports state (output, 2 bits) and err (output, 1 bit).
REQ-011 SHALL have ports stall_cycles and redirect_count, output, 16 bits each: performance counters.

Function
REQ-012 SHALL implement states RUN=0, MEM_WAIT=1, ERROR=2; encoding 3 is unused and SHALL return to RUN on the next clock.
REQ-013 SHALL treat load_use as true when id_valid & ex_load & ex_reg_write & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-014 SHALL treat mem_busy as true when dmem_req & !dmem_ack.
REQ-015 SHALL drive all control outputs combinationally from the current state and inputs, in the same cycle, with zero latency.
REQ-016 In RUN with mem_busy, SHALL assert all four *_stall outputs, deassert both flushes and pc_redirect, and go to MEM_WAIT.
REQ-017 In RUN with mem_busy & ex_redirect, SHALL latch redirect_target and set a pending flag, with no flush that cycle.
REQ-018 In RUN with ex_redirect & !mem_busy, SHALL assert if_id_flush, id_ex_flush and pc_redirect, drive pc_target=redirect_target, assert no stall, and stay in RUN.
REQ-019 In RUN with load_use & !ex_redirect & !mem_busy, SHALL assert pc_stall, if_id_stall and id_ex_flush (one-cycle bubble).
REQ-020 In RUN with load_use, SHALL leave id_ex_stall and ex_mem_stall at 0.
REQ-021 SHALL apply priority mem_busy > ex_redirect > load_use.
REQ-022 In MEM_WAIT while !dmem_ack, SHALL assert all four *_stall outputs, ignore ex_redirect and load_use, and increment the wait timer.
REQ-023 In MEM_WAIT on dmem_ack=1, SHALL deassert all stalls and return to RUN, clearing the wait timer.
REQ-024 In that dmem_ack cycle, if pending is set, SHALL also assert both flushes and pc_redirect with pc_target = the latched target, and clear pending.
REQ-025 In that dmem_ack cycle, if pending is clear, SHALL evaluate load_use as in RUN.
REQ-026 The wait timer SHALL be 8 bits and count consecutive MEM_WAIT cycles without ack.
REQ-027 When the wait timer reaches 255 with no ack, the next edge SHALL enter ERROR.
REQ-028 ERROR SHALL be sticky until rst, hold all four *_stall=1 and err=1, and ignore dmem_ack.
REQ-029 stall_cycles SHALL increment on each cycle in which pc_stall=1, saturating at 0xFFFF.
REQ-030 redirect_count SHALL increment on each cycle in which pc_redirect=1, saturating at 0xFFFF.
REQ-031 pc_target SHALL be 0 whenever pc_redirect=0.

Reset
REQ-032 While rst=1 at a rising edge, SHALL set state=RUN and clear pending, the latched target, the wait timer, err, stall_cycles and redirect_count.
REQ-033 While rst=1, SHALL force all control outputs and pc_target to 0, regardless of inputs.
REQ-034 Reset asserted mid-MEM_WAIT or in ERROR SHALL discard any pending redirect.
REQ-035 One cycle after rst deasserts, the block SHALL be in RUN.

Verification
REQ-036 Load-use: ex_load=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, id_valid=1 -> pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle; stall_cycles=1.
REQ-037 ex_rd=0 with otherwise identical load-use stimulus -> no stall, no flush.
REQ-038 ex_redirect=1, redirect_target=0x00000080, load_use=1 same cycle -> flushes=1, pc_redirect=1, pc_target=0x80, pc_stall=0; redirect_count=1.
REQ-039 dmem_req=1 with ack after 3 cycles, plus ex_redirect with target 0x100 in the first cycle -> 3 cycles of all stalls (state=1), then one cycle with pc_redirect=1, pc_target=0x100 and both flushes, then state=0.
REQ-040 dmem_req=1 with no ack for 257 cycles -> state=2, err=1, stalls held; rst pulse -> state=0, err=0, counters=0.
REQ-041 Force stall_cycles to 0xFFFF, then apply a load-use -> stall_cycles remains 0xFFFF.
